// File: rtl/hdmi_dual_rd_sched_if.sv
// Bundle between the dual-camera read scheduler and its FIFO / HDMI timing environment.
// master drives sync, requests and FIFO status; slave is the scheduler.
interface hdmi_dual_rd_sched_if #(
    parameter int unsigned FIFO_AW = 10
);
    logic               video_vs;
    logic               data_req;
    logic [FIFO_AW-1:0] cam0_rd_cnt;
    logic [FIFO_AW-1:0] cam1_rd_cnt;
    logic               cam0_rd_empty;
    logic               cam1_rd_empty;
    logic [15:0]        cam0_rd_data;
    logic [15:0]        cam1_rd_data;
    logic               cam0_rd_en;
    logic               cam1_rd_en;
    logic               rd_load;
    logic [15:0]        pixel_data;
    logic               running;
    logic [15:0]        underflow_cnt;

    modport master (
        output video_vs, data_req, cam0_rd_cnt, cam1_rd_cnt,
               cam0_rd_empty, cam1_rd_empty, cam0_rd_data, cam1_rd_data,
        input  cam0_rd_en, cam1_rd_en, rd_load, pixel_data, running, underflow_cnt
    );

    modport slave (
        input  video_vs, data_req, cam0_rd_cnt, cam1_rd_cnt,
               cam0_rd_empty, cam1_rd_empty, cam0_rd_data, cam1_rd_data,
        output cam0_rd_en, cam1_rd_en, rd_load, pixel_data, running, underflow_cnt
    );
endinterface

// File: rtl/hdmi_dual_rd_sched.sv
// Dual-camera frame-buffer read scheduler for a 1280x720 HDMI scanout:
// left columns from camera 0, right columns from camera 1, blank on underflow.
module hdmi_dual_rd_sched #(
    parameter int unsigned H_SPLIT     = 640,
    parameter int unsigned LOAD_CYCLES = 8,
    parameter int unsigned PREFILL     = 256,
    parameter int unsigned FIFO_AW     = 10,
    parameter logic [15:0] BLANK_COLOR = 16'h0000
) (
    input  logic                 pixel_clk,
    input  logic                 sys_rst,
    hdmi_dual_rd_sched_if.slave  bus
);
    localparam int unsigned LCW = $clog2(LOAD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t       state_r, state_nxt_s;
    logic         vs_d_r, vs_fall_s;
    logic [LCW-1:0] load_cnt_r;
    logic         load_done_s, fill_ok_s;
    logic         rd_load_r;
    logic [10:0]  col_r;
    logic         issue_s, sel1_s, uf_s, rd0_s, rd1_s;
    logic         cam0_rd_en_r, cam1_rd_en_r;
    logic         act_p1_r, sel1_p1_r, uf_p1_r;
    logic         act_p2_r, sel1_p2_r, uf_p2_r;
    logic [15:0]  uf_cnt_r;
    logic [15:0]  pix_s;

    assign vs_fall_s   = vs_d_r & ~bus.video_vs;
    assign load_done_s = (load_cnt_r == LCW'(LOAD_CYCLES - 1));
    assign fill_ok_s   = (32'(bus.cam0_rd_cnt) >= PREFILL) && (32'(bus.cam1_rd_cnt) >= PREFILL);

    // Next-state logic; a frame start always (re)starts the load pulse
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (vs_fall_s) state_nxt_s = LOAD;
                else           state_nxt_s = IDLE;
            end
            LOAD: begin
                if (vs_fall_s)        state_nxt_s = LOAD;
                else if (load_done_s) state_nxt_s = FILL;
                else                  state_nxt_s = LOAD;
            end
            FILL: begin
                if (vs_fall_s)      state_nxt_s = LOAD;
                else if (fill_ok_s) state_nxt_s = RUN;
                else                state_nxt_s = FILL;
            end
            RUN: begin
                if (vs_fall_s) state_nxt_s = LOAD;
                else           state_nxt_s = RUN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read decision for the pixel requested this cycle; an empty FIFO is never read
    always_comb begin
        issue_s = (state_r == RUN) && bus.data_req;
        sel1_s  = (32'(col_r) >= H_SPLIT);
        if (sel1_s) begin
            uf_s  = issue_s && bus.cam1_rd_empty;
            rd0_s = 1'b0;
            rd1_s = issue_s && !bus.cam1_rd_empty;
        end else begin
            uf_s  = issue_s && bus.cam0_rd_empty;
            rd0_s = issue_s && !bus.cam0_rd_empty;
            rd1_s = 1'b0;
        end
    end

    // Sync edge detect, FSM state and load-pulse timing
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r    <= IDLE;
            vs_d_r     <= 1'b0;
            load_cnt_r <= '0;
            rd_load_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            vs_d_r  <= bus.video_vs;
            if (state_r == LOAD && !vs_fall_s && !load_done_s) begin
                load_cnt_r <= load_cnt_r + LCW'(1);
            end else begin
                load_cnt_r <= '0;
            end
            rd_load_r <= (state_r == LOAD);
        end
    end

    // Column count, read strobes and the two-stage select/underflow pipeline
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_r        <= 11'd0;
            cam0_rd_en_r <= 1'b0;
            cam1_rd_en_r <= 1'b0;
            act_p1_r     <= 1'b0;
            sel1_p1_r    <= 1'b0;
            uf_p1_r      <= 1'b0;
            act_p2_r     <= 1'b0;
            sel1_p2_r    <= 1'b0;
            uf_p2_r      <= 1'b0;
            uf_cnt_r     <= 16'h0000;
        end else begin
            col_r        <= bus.data_req ? (col_r + 11'd1) : 11'd0;
            cam0_rd_en_r <= rd0_s;
            cam1_rd_en_r <= rd1_s;
            act_p1_r     <= issue_s;
            sel1_p1_r    <= sel1_s;
            uf_p1_r      <= uf_s;
            act_p2_r     <= act_p1_r;
            sel1_p2_r    <= sel1_p1_r;
            uf_p2_r      <= uf_p1_r;
            if (uf_s && (uf_cnt_r != 16'hFFFF)) begin
                uf_cnt_r <= uf_cnt_r + 16'd1;
            end
        end
    end

    // FIFO words arrive one cycle after the strobe, so the mux select is two stages deep
    always_comb begin
        pix_s = BLANK_COLOR;
        if (act_p2_r && !uf_p2_r) begin
            pix_s = sel1_p2_r ? bus.cam1_rd_data : bus.cam0_rd_data;
        end else begin
            pix_s = BLANK_COLOR;
        end
    end

    assign bus.cam0_rd_en    = cam0_rd_en_r;
    assign bus.cam1_rd_en    = cam1_rd_en_r;
    assign bus.rd_load       = rd_load_r;
    assign bus.running       = (state_r == RUN);
    assign bus.pixel_data    = pix_s;
    assign bus.underflow_cnt = uf_cnt_r;
endmodule
